// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2/stride-2 pooling window generator.
// The max2 helper is only used when POOL_WINDOW_MAX_EN is defined.
package pool_pkg;

    localparam int DEF_DATA_W = 17;
    localparam int MAX_W      = 64;

    function automatic int lane_off(input int lane, input int width);
        return lane * width;
    endfunction

    // Operands are sign-extended to MAX_W by the caller.
    function automatic logic signed [MAX_W-1:0] max2(input logic signed [MAX_W-1:0] x,
                                                     input logic signed [MAX_W-1:0] y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/pool_line_mem.sv
// One-row line buffer: single write port, two asynchronous read ports.
// Contents are not reset; every slot is rewritten on each even row before it is read.
module pool_line_mem
    import pool_pkg::*;
#(
    parameter int W     = DEF_DATA_W,
    parameter int DEPTH = 28,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    output logic [W-1:0]  o_rdata0,
    output logic [W-1:0]  o_rdata1
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/pool_window_gen.sv
// 2x2/stride-2 pooling window generator over a raster stream of CH lanes.
// Define POOL_WINDOW_MAX_EN to add out_max, the registered per-lane signed max of the window.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH     = 1,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_a,
    output logic [CH*DATA_W-1:0] out_b,
    output logic [CH*DATA_W-1:0] out_c,
    output logic [CH*DATA_W-1:0] out_d,
    output logic                 out_last
`ifdef POOL_WINDOW_MAX_EN
   ,output logic [CH*DATA_W-1:0] out_max
`endif
);

    localparam int LW = CH * DATA_W;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
        $error("pool_window_gen: IMG_W and IMG_H must be even and >= 2");
    end

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [LW-1:0] r_left, r_a, r_b, r_c, r_d;
    logic          r_out_valid, r_last;

    logic          w_accept, w_col_end, w_row_end, w_pair, w_lb_we;
    logic [CW-1:0] w_col_m1;
    logic [LW-1:0] w_lb_left, w_lb_right;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    assign w_pair    = r_row[0] && r_col[0];
    assign w_col_m1  = r_col - CW'(1);
    assign w_lb_we   = w_accept && !r_row[0] && !clear;

    pool_line_mem #(.W(LW), .DEPTH(IMG_W), .AW(CW)) u_line (
        .clk      (clk),
        .i_we     (w_lb_we),
        .i_waddr  (r_col),
        .i_wdata  (in_data),
        .i_raddr0 (w_col_m1),
        .i_raddr1 (r_col),
        .o_rdata0 (w_lb_left),
        .o_rdata1 (w_lb_right)
    );

`ifdef POOL_WINDOW_MAX_EN
    logic [LW-1:0] w_max, r_max;

    for (genvar k = 0; k < CH; k++) begin : g_max
        localparam int O = lane_off(k, DATA_W);
        logic signed [MAX_W-1:0] w_sa, w_sb, w_sc, w_sd;
        assign w_sa = MAX_W'(signed'(w_lb_left[O +: DATA_W]));
        assign w_sb = MAX_W'(signed'(w_lb_right[O +: DATA_W]));
        assign w_sc = MAX_W'(signed'(r_left[O +: DATA_W]));
        assign w_sd = MAX_W'(signed'(in_data[O +: DATA_W]));
        assign w_max[O +: DATA_W] = DATA_W'(max2(max2(w_sa, w_sb), max2(w_sc, w_sd)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                r_max <= '0;
        else if (!clear && w_accept && w_pair)    r_max <= w_max;
    end

    assign out_max = r_max;
`endif

    // clear outranks both the input accept and the output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_left      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
        end else if (clear) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_accept) begin
                r_col <= w_col_end ? '0 : r_col + CW'(1);
                if (w_col_end) r_row <= w_row_end ? '0 : r_row + RW'(1);
                if (r_row[0] && !r_col[0]) r_left <= in_data;
                if (w_pair) begin
                    r_a         <= w_lb_left;
                    r_b         <= w_lb_right;
                    r_c         <= r_left;
                    r_d         <= in_data;
                    r_out_valid <= 1'b1;
                    r_last      <= w_row_end && w_col_end;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_last;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_c     = r_c;
    assign out_d     = r_d;

endmodule
